// File: rtl/count_accum_pkg.sv
// Shared types and sizing helpers for the counter-sum ("somador") stage.
// Imported by count_accumulator.
package count_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int unsigned DEFAULT_WIDTH     = 4;
    localparam int unsigned DEFAULT_N_SAMPLES = 8;

    // Sum width large enough for n_samples * (2^width - 1).
    function automatic int unsigned sum_width(input int unsigned width,
                                              input int unsigned n_samples);
        return width + $clog2(n_samples);
    endfunction

endpackage

// File: rtl/count_accumulator.sv
// Sums N_SAMPLES counter values taken over a valid/ready handshake and offers
// the total downstream over a second valid/ready handshake.
module count_accumulator
    import count_accum_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned N_SAMPLES = DEFAULT_N_SAMPLES
) (
    input  logic                                  Clk,
    input  logic                                  clear,
    input  logic                                  start,
    input  logic [WIDTH-1:0]                      count_in,
    input  logic                                  count_valid,
    output logic                                  count_ready,
    output logic [sum_width(WIDTH, N_SAMPLES)-1:0] sum_out,
    output logic                                  sum_valid,
    input  logic                                  sum_ready,
    output logic                                  busy,
    output logic [$clog2(N_SAMPLES)-1:0]          sample_idx
);

    localparam int unsigned SUM_W = sum_width(WIDTH, N_SAMPLES);
    localparam int unsigned IDX_W = $clog2(N_SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    state_t           state;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] count_ext;

    assign count_ext   = SUM_W'(count_in);
    assign count_ready = (state == ACCUM);
    assign busy        = (state != IDLE);

    always_ff @(posedge Clk or posedge clear) begin
        if (clear) begin
            state      <= IDLE;
            acc        <= '0;
            sum_out    <= '0;
            sum_valid  <= 1'b0;
            sample_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        acc        <= '0;
                        sample_idx <= '0;
                    end
                end
                ACCUM: begin
                    if (count_valid) begin
                        if (sample_idx == LAST_IDX) begin
                            // Final sample goes straight into the result so it
                            // is visible on the same edge that accepts it.
                            state      <= DONE;
                            sum_out    <= acc + count_ext;
                            sum_valid  <= 1'b1;
                            sample_idx <= '0;
                        end else begin
                            acc        <= acc + count_ext;
                            sample_idx <= sample_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        if (start) begin
                            state      <= ACCUM;
                            acc        <= '0;
                            sample_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    sum_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_accumulator.sv
// Self-checking bench for count_accumulator: directed scenarios plus random
// runs, all compared against a queue-based model of the accumulation rules.
module tb_count_accumulator;

    localparam int W  = 4;
    localparam int N  = 8;
    localparam int SW = 7;
    localparam int IW = 3;

    logic          Clk = 1'b0;
    logic          clear;
    logic          start;
    logic [W-1:0]  count_in;
    logic          count_valid;
    logic          count_ready;
    logic [SW-1:0] sum_out;
    logic          sum_valid;
    logic          sum_ready;
    logic          busy;
    logic [IW-1:0] sample_idx;

    bit clk_en = 1'b1;
    int checks = 0;
    int errors = 0;

    // Model: phase 0 = waiting, 1 = collecting, 2 = holding a result.
    int          m_phase;
    int unsigned taken[$];
    int unsigned m_sum;
    bit          m_valid;

    count_accumulator #(.WIDTH(W), .N_SAMPLES(N)) dut (
        .Clk         (Clk),
        .clear       (clear),
        .start       (start),
        .count_in    (count_in),
        .count_valid (count_valid),
        .count_ready (count_ready),
        .sum_out     (sum_out),
        .sum_valid   (sum_valid),
        .sum_ready   (sum_ready),
        .busy        (busy),
        .sample_idx  (sample_idx)
    );

    always begin
        #5;
        if (clk_en) Clk = ~Clk;
    end

    function automatic int unsigned qsum();
        int unsigned s = 0;
        foreach (taken[i]) s += taken[i];
        return s;
    endfunction

    function automatic void model_clear();
        m_phase = 0;
        taken.delete();
        m_sum   = 0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_step();
        case (m_phase)
            0: if (start) begin m_phase = 1; taken.delete(); end
            1: if (count_valid) begin
                taken.push_back(int'(count_in));
                if (taken.size() == N) begin
                    m_sum   = qsum();
                    m_valid = 1'b1;
                    m_phase = 2;
                    taken.delete();
                end
            end
            default: if (sum_ready) begin
                m_valid = 1'b0;
                if (start) begin m_phase = 1; taken.delete(); end
                else m_phase = 0;
            end
        endcase
    endfunction

    function automatic int unsigned m_idx();
        return (m_phase == 1) ? taken.size() : 0;
    endfunction

    // Advance one edge; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic feed(input int unsigned v);
        count_valid = 1'b1;
        count_in    = W'(v);
        tick();
        count_valid = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < N; i++) feed($urandom_range(1, 15));
        clk_en = 1'b0;
        #10;
        clear = 1'b1;
        model_clear();
        #1;
        checks++;
        if ({busy, count_ready, sum_valid} !== 3'b000 || sum_out !== '0 || sample_idx !== '0) begin
            errors++;
            $display("FAIL reset_async got busy=%b rdy=%b vld=%b sum=%0d idx=%0d want all 0",
                     busy, count_ready, sum_valid, sum_out, sample_idx);
        end
        #3 clear = 1'b0;
        #2 clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle got rdy=%b busy=%b want 0 0", count_ready, busy);
            end
        end
    endtask

    task automatic test_sequential();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < N; i++) begin
            feed(i);
            checks++;
            if (sum_valid !== m_valid) begin
                errors++;
                $display("FAIL seq_valid step %0d got %b want %b", i, sum_valid, m_valid);
            end
        end
        checks++;
        if (sum_out !== SW'(28) || sum_out !== SW'(m_sum) || busy !== 1'b1) begin
            errors++;
            $display("FAIL seq_sum got %0d busy=%b want 28 busy=1", sum_out, busy);
        end
        sum_ready = 1'b1; tick(); sum_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_release got busy=%b vld=%b want 0 0", busy, sum_valid);
        end
    endtask

    task automatic test_gaps();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < N; i++) begin
            feed(15);
            for (int g = 0; g < 2; g++) begin
                count_in = W'($urandom);
                tick();
                checks++;
                if (sample_idx !== IW'(m_idx())) begin
                    errors++;
                    $display("FAIL gap_idx got %0d want %0d", sample_idx, m_idx());
                end
            end
        end
        checks++;
        if (sum_out !== SW'(120) || sum_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_sum got %0d vld=%b want 120 vld=1", sum_out, sum_valid);
        end
    endtask

    // Continues from the DONE state left by test_gaps.
    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            count_valid = 1'($urandom);
            count_in    = W'($urandom);
            tick();
            checks++;
            if (sum_out !== SW'(120) || sum_valid !== 1'b1 || count_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall got sum=%0d vld=%b rdy=%b want 120 1 0",
                         sum_out, sum_valid, count_ready);
            end
        end
        count_valid = 1'b0;
        sum_ready = 1'b1; tick(); sum_ready = 1'b0;
        checks++;
        if (sum_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got vld=%b busy=%b want 0 0", sum_valid, busy);
        end
    endtask

    task automatic test_clear_midrun();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) feed(5);
        #2 clear = 1'b1;
        model_clear();
        #1;
        checks++;
        if (busy !== 1'b0 || sum_valid !== 1'b0 || sample_idx !== '0 || sum_out !== '0) begin
            errors++;
            $display("FAIL clear_mid got busy=%b vld=%b idx=%0d sum=%0d want 0 0 0 0",
                     busy, sum_valid, sample_idx, sum_out);
        end
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sum_valid !== 1'b0) begin
                errors++;
                $display("FAIL clear_noresult got vld=%b want 0", sum_valid);
            end
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < N; i++) feed(1);
        checks++;
        if (sum_out !== SW'(8) || sum_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_rerun got %0d vld=%b want 8 vld=1", sum_out, sum_valid);
        end
    endtask

    // Enters with the previous result still pending.
    task automatic test_back_to_back();
        sum_ready = 1'b1; tick(); sum_ready = 1'b0;
        start = 1'b1; tick();
        for (int i = 0; i < N; i++) begin
            start = 1'($urandom);
            feed($urandom_range(0, 15));
        end
        start = 1'b0;
        checks++;
        if (sum_out !== SW'(m_sum) || sum_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ignore_start got %0d want %0d", sum_out, m_sum);
        end
        start = 1'b1; sum_ready = 1'b1; tick(); start = 1'b0; sum_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || count_ready !== 1'b1 || sum_valid !== 1'b0 || sample_idx !== '0) begin
            errors++;
            $display("FAIL b2b_restart got busy=%b rdy=%b vld=%b idx=%0d want 1 1 0 0",
                     busy, count_ready, sum_valid, sample_idx);
        end
        for (int i = 0; i < N; i++) feed(2);
        checks++;
        if (sum_out !== SW'(16) || sum_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sum got %0d vld=%b want 16 vld=1", sum_out, sum_valid);
        end
        sum_ready = 1'b1; tick(); sum_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            start       = ($urandom_range(0, 9) < 2);
            count_valid = ($urandom_range(0, 9) < 7);
            count_in    = W'($urandom);
            sum_ready   = ($urandom_range(0, 9) < 3);
            tick();
            checks++;
            if (sum_valid !== m_valid || busy !== (m_phase != 0) ||
                count_ready !== (m_phase == 1) || sample_idx !== IW'(m_idx()) ||
                sum_out !== SW'(m_sum)) begin
                errors++;
                $display("FAIL random cyc %0d got vld=%b busy=%b rdy=%b idx=%0d sum=%0d want %b %b %b %0d %0d",
                         c, sum_valid, busy, count_ready, sample_idx, sum_out,
                         m_valid, m_phase != 0, m_phase == 1, m_idx(), m_sum);
            end
        end
        start = 1'b0; count_valid = 1'b0; sum_ready = 1'b0;
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; count_valid = 1'b0; count_in = '0; sum_ready = 1'b0;
        model_clear();
        #12 clear = 1'b0;
        @(posedge Clk);
        #1;
        test_reset();
        test_sequential();
        test_gaps();
        test_stall();
        test_clear_midrun();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
